dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single 512-word x 32-bit data memory between two requesters: port 0 (core load/store unit) and port 1 (debug/DMA loader).
- Arbitrates one access per cycle, round-robin by default.
- Registers the winning command onto the memory's wr/rd/addr/wr_data bus and routes rd_data back to the issuing port.
- Supports a bounded bus lock for atomic read-modify-write.

Parameters:
- ADDR_W, 9, memory word-address width
- DATA_W, 32, data width
- LOCK_MAX, 16, maximum consecutive cycles a port may hold the lock before forced release

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_i[1:0]  in  2  access request per port
- we_i[1:0]  in  2  1 = write, 0 = read; per port
- lock_i[1:0]  in  2  keep ownership after this access; per port
- addr0_i / addr1_i  in  ADDR_W  word address
- wdata0_i / wdata1_i  in  DATA_W  write data
- gnt_o[1:0]  out  2  request accepted this cycle
- rvalid_o[1:0]  out  2  read data valid for that port
- rdata_o  out  DATA_W  read data, shared, qualified by rvalid_o
- lock_err_o  out  1  sticky, set on forced lock release
- wr  out  1  memory write strobe
- rd  out  1  memory read strobe
- addr  out  ADDR_W  memory address
- wr_data  out  DATA_W  memory write data
- rd_data  in  DATA_W  memory read data, valid one cycle after rd

Behaviour:
- Reset (reset=0, async):
  - gnt_o, rvalid_o, wr, rd, lock_err_o = 0; addr, wr_data, rdata_o = 0.
  - RR pointer = 0 (port 0 preferred); FSM = ARB; lock counter = 0.
  - An in-flight read is dropped and no rvalid is produced.
- Handshake:
  - gnt_o is combinational from req_i, FSM state and RR pointer.
  - A transfer occurs in cycle N when req_i[p] & gnt_o[p]; at most one gnt bit is high.
  - The requester holds we/addr/wdata/lock stable while req is high and gnt is low.
- Command timing:
  - The winner's command is registered: wr (we=1) or rd (we=0), plus addr and wr_data, drive the memory for exactly cycle N+1.
  - wr and rd are never both high.
- Read return:
  - rd_data is valid in cycle N+2; rvalid_o[p] = 1 for cycle N+2 only; rdata_o = rd_data.
  - Back-to-back grants every cycle are allowed, giving a fully pipelined throughput of 1 access/cycle.
- Round-robin:
  - If both ports request in state ARB, the port selected by the pointer wins.
  - After any grant, the pointer moves to the non-granted port.
  - A single requester wins regardless of the pointer.
- FSM states: ARB, LOCK0, LOCK1.
  - ARB -> LOCKp when port p is granted with lock_i[p]=1; the lock counter is cleared.
  - In LOCKp only port p can be granted; the other port's req waits with gnt low.
  - LOCKp -> ARB when port p is granted with lock_i[p]=0, or port p deasserts lock_i[p] while idle.
  - Forced release: the lock counter increments each cycle in LOCKp. When it reaches LOCK_MAX-1, the FSM returns to ARB, lock_err_o sets, and the RR pointer moves to the other port. Any grant in that same cycle is still honoured.
- lock_err_o clears only on reset.
- Address and data are passed unmodified; there is no wrap or bounds logic. ADDR_W bits are driven directly.

Optional Feature:
- DMEM_ARB_FIXED_PRIO_EN
  - Defined: the RR pointer is removed and port 0 always wins simultaneous requests in ARB. Lock behaviour is unchanged.
  - Undefined: round-robin as above.

Decomposition:
- Package dmem_arb_pkg holds:
  - typedef enum logic [1:0] {ARB, LOCK0, LOCK1} arb_state_t
  - localparams NUM_PORTS=2, ADDR_W=9, DATA_W=32
  - typedef struct mem_cmd_t {we, addr, wdata}
- One sub-module, dmem_arb_rr: 2-way grant logic with pointer update and the fixed-priority macro.
- dmem_arbiter holds the FSM, lock counter, command register and read-return pipeline.

Test Plan:
- Port 0 reads addr 5 in cycle N (memory word = 0x0000_00AB):
  - rd=1 and addr=5 in N+1.
  - rvalid_o=2'b01 and rdata_o=0x0000_00AB in N+2.
- Both ports write every cycle for 4 cycles (addr 1/2, data 0x11/0x22):
  - grants alternate 01, 10, 01, 10.
  - The memory sees 4 consecutive wr with alternating addr 1, 2.
  - With DMEM_ARB_FIXED_PRIO_EN: grants are 01 x4.
- Port 1 locks (write addr 7) and holds lock 3 cycles while port 0 requests:
  - gnt_o[0] stays 0 until port 1 releases.
  - Port 0 is granted the cycle after release.
- Port 1 holds lock_i=1 indefinitely with LOCK_MAX=16:
  - Forced return to ARB after 16 cycles; lock_err_o=1.
  - The pending port 0 request is granted the next cycle.
- reset driven low in cycle N+1 of a port 0 read:
  - All outputs are 0 immediately.
  - No rvalid_o after reset release.
  - The first simultaneous request afterwards is granted to port 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// ============================================================================
//  Module   : dmem_arb_pkg
//  Brief    : Shared types and constants for the data-memory arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

    localparam int NUM_PORTS = 2;
    localparam int ADDR_W    = 9;
    localparam int DATA_W    = 32;

    // ARB: both ports compete; LOCKp: only port p may be granted
    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    // One memory command as issued by a requester
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage

`default_nettype wire

// File: rtl/dmem_arb_rr.sv
// ============================================================================
//  Module   : dmem_arb_rr
//  Brief    : Two-way grant logic. Round-robin pointer by default; when
//             DMEM_ARB_FIXED_PRIO_EN is defined the pointer is removed and
//             port 0 always wins simultaneous requests.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arb_rr
    import dmem_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,       // asynchronous, active-low
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [NUM_PORTS-1:0] i_allow,     // ports eligible this cycle
    input  logic                 i_force_upd, // forced lock release this cycle
    input  logic                 i_force_ptr, // pointer value on forced release
    output logic [NUM_PORTS-1:0] o_gnt
);

    logic [NUM_PORTS-1:0] w_req;

    assign w_req = i_req & i_allow;

`ifdef DMEM_ARB_FIXED_PRIO_EN

    logic w_unused;
    assign w_unused = &{1'b0, clk, reset, i_force_upd, i_force_ptr};

    // Fixed priority: port 0 beats port 1
    always_comb begin
        o_gnt = '0;
        if (w_req[0]) begin
            o_gnt = 2'b01;
        end else if (w_req[1]) begin
            o_gnt = 2'b10;
        end
    end

`else

    logic r_ptr; // 0: port 0 preferred, 1: port 1 preferred

    // Round-robin grant: single requester always wins, ties go to the pointer
    always_comb begin
        o_gnt = '0;
        case (w_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = r_ptr ? 2'b10 : 2'b01;
            default: o_gnt = '0;
        endcase
    end

    // Pointer moves to the port that was not granted (or as forced)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= 1'b0;
        end else if (i_force_upd) begin
            r_ptr <= i_force_ptr;
        end else if (|o_gnt) begin
            r_ptr <= o_gnt[0];
        end
    end

`endif

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
//  Module   : dmem_arbiter
//  Brief    : Shares one data memory between the load/store unit (port 0)
//             and the debug/DMA loader (port 1). One access per cycle,
//             registered command bus, read data routed back two cycles after
//             the grant, bounded bus lock for read-modify-write.
//             Optional macro DMEM_ARB_FIXED_PRIO_EN selects fixed priority.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int ADDR_W   = dmem_arb_pkg::ADDR_W,
    parameter int DATA_W   = dmem_arb_pkg::DATA_W,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              reset,      // asynchronous, active-low
    input  logic [1:0]        req_i,
    input  logic [1:0]        we_i,
    input  logic [1:0]        lock_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic [1:0]        gnt_o,
    output logic [1:0]        rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              lock_err_o,
    output logic              wr,
    output logic              rd,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rd_data
);

    import dmem_arb_pkg::*;

    localparam int                 c_CNT_W     = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [c_CNT_W-1:0] c_LOCK_LAST = c_CNT_W'(LOCK_MAX - 1);

    arb_state_t           r_state, w_state_nxt;
    logic [c_CNT_W-1:0]   r_lock_cnt, w_lock_cnt_nxt;
    logic                 w_force_rel;
    logic                 w_force_ptr;
    logic [NUM_PORTS-1:0] w_allow;
    logic [NUM_PORTS-1:0] w_gnt;

    logic                 w_sel;
    logic                 w_sel_we;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [DATA_W-1:0]    w_sel_wdata;

    logic                 r_wr, r_rd, r_rd_port;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic [1:0]           r_rvalid;
    logic                 r_lock_err;

    // Eligible ports: none in reset, only the owner while locked
    assign w_allow = !reset            ? 2'b00 :
                     (r_state == LOCK0) ? 2'b01 :
                     (r_state == LOCK1) ? 2'b10 : 2'b11;

    dmem_arb_rr u_rr (
        .clk         (clk),
        .reset       (reset),
        .i_req       (req_i),
        .i_allow     (w_allow),
        .i_force_upd (w_force_rel),
        .i_force_ptr (w_force_ptr),
        .o_gnt       (w_gnt)
    );

    assign gnt_o = w_gnt;

    // Winning port's command
    assign w_sel       = w_gnt[1];
    assign w_sel_we    = w_sel ? we_i[1]  : we_i[0];
    assign w_sel_addr  = w_sel ? addr1_i  : addr0_i;
    assign w_sel_wdata = w_sel ? wdata1_i : wdata0_i;

    // Lock FSM next state, lock counter and forced-release detection
    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = r_lock_cnt;
        w_force_rel    = 1'b0;
        w_force_ptr    = 1'b0;
        case (r_state)
            ARB: begin
                w_lock_cnt_nxt = '0;
                if (w_gnt[0] && lock_i[0]) begin
                    w_state_nxt = LOCK0;
                end else if (w_gnt[1] && lock_i[1]) begin
                    w_state_nxt = LOCK1;
                end
            end
            LOCK0: begin
                w_lock_cnt_nxt = r_lock_cnt + 1'b1;
                if (r_lock_cnt == c_LOCK_LAST) begin
                    w_state_nxt    = ARB;
                    w_lock_cnt_nxt = '0;
                    w_force_rel    = 1'b1;
                    w_force_ptr    = 1'b1;
                end else if (!lock_i[0] && (w_gnt[0] || !req_i[0])) begin
                    w_state_nxt    = ARB;
                    w_lock_cnt_nxt = '0;
                end
            end
            LOCK1: begin
                w_lock_cnt_nxt = r_lock_cnt + 1'b1;
                if (r_lock_cnt == c_LOCK_LAST) begin
                    w_state_nxt    = ARB;
                    w_lock_cnt_nxt = '0;
                    w_force_rel    = 1'b1;
                    w_force_ptr    = 1'b0;
                end else if (!lock_i[1] && (w_gnt[1] || !req_i[1])) begin
                    w_state_nxt    = ARB;
                    w_lock_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt    = ARB;
                w_lock_cnt_nxt = '0;
            end
        endcase
    end

    // Lock FSM state, counter and sticky error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ARB;
            r_lock_cnt <= '0;
            r_lock_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_lock_err <= r_lock_err | w_force_rel;
        end
    end

    // Register the granted command onto the memory bus for one cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr      <= 1'b0;
            r_rd      <= 1'b0;
            r_rd_port <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else begin
            r_wr <= (|w_gnt) &  w_sel_we;
            r_rd <= (|w_gnt) & ~w_sel_we;
            if (|w_gnt) begin
                r_rd_port <= w_sel;
                r_addr    <= w_sel_addr;
                r_wdata   <= w_sel_wdata;
            end
        end
    end

    // Read-return pipeline: memory data arrives the cycle after rd
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rvalid <= 2'b00;
        end else begin
            r_rvalid <= r_rd ? (r_rd_port ? 2'b10 : 2'b01) : 2'b00;
        end
    end

    assign wr         = r_wr;
    assign rd         = r_rd;
    assign addr       = r_addr;
    assign wr_data    = r_wdata;
    assign rvalid_o   = r_rvalid;
    assign rdata_o    = (|r_rvalid) ? rd_data : '0;
    assign lock_err_o = r_lock_err;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Brief    : Self-checking bench for dmem_arbiter with a behavioural memory
//             and a scoreboard for memory commands and read returns.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req, we, lock;
    logic [8:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic [1:0]  gnt_o, rvalid_o;
    logic [31:0] rdata_o;
    logic        lock_err_o;
    logic        wr, rd;
    logic [8:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    logic [31:0] mem    [0:511];
    logic [31:0] shadow [0:511];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int          cyc;
        logic        we;
        logic        port;
        logic [8:0]  addr;
        logic [31:0] data;
    } xfer_t;

    xfer_t cmd_q[$];
    xfer_t rd_q[$];

    dmem_arbiter #(
        .ADDR_W   (9),
        .DATA_W   (32),
        .LOCK_MAX (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_i      (req),
        .we_i       (we),
        .lock_i     (lock),
        .addr0_i    (addr0),
        .addr1_i    (addr1),
        .wdata0_i   (wdata0),
        .wdata1_i   (wdata1),
        .gnt_o      (gnt_o),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .lock_err_o (lock_err_o),
        .wr         (wr),
        .rd         (rd),
        .addr       (addr),
        .wr_data    (wr_data),
        .rd_data    (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural synchronous memory: read data one cycle after rd
    always @(posedge clk) begin
        if (wr) mem[addr] <= wr_data;
        if (rd) rd_data   <= mem[addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare the memory bus and read returns against recorded transfers
    always @(negedge clk) begin
        xfer_t       x;
        logic        e_wr, e_rd;
        logic [1:0]  e_rv;
        cyc++;
        if (!reset) begin
            cmd_q.delete();
            rd_q.delete();
        end else begin
            e_wr = 1'b0;
            e_rd = 1'b0;
            if (cmd_q.size() > 0 && cmd_q[0].cyc == cyc - 1) begin
                x    = cmd_q.pop_front();
                e_wr = x.we;
                e_rd = !x.we;
                check_eq("mem_addr", {23'd0, addr}, {23'd0, x.addr});
                if (x.we) check_eq("mem_wdata", wr_data, x.data);
            end
            check_eq("mem_wr", {31'd0, wr}, {31'd0, e_wr});
            check_eq("mem_rd", {31'd0, rd}, {31'd0, e_rd});
            e_rv = 2'b00;
            if (rd_q.size() > 0 && rd_q[0].cyc == cyc - 2) begin
                x    = rd_q.pop_front();
                e_rv = x.port ? 2'b10 : 2'b01;
                check_eq("rdata", rdata_o, x.data);
            end
            check_eq("rvalid", {30'd0, rvalid_o}, {30'd0, e_rv});
            for (int p = 0; p < 2; p++) begin
                if (req[p] && gnt_o[p]) begin
                    x.cyc  = cyc;
                    x.we   = we[p];
                    x.port = (p == 1);
                    x.addr = (p == 1) ? addr1 : addr0;
                    x.data = (p == 1) ? wdata1 : wdata0;
                    if (x.we) shadow[x.addr] = x.data;
                    else      x.data = shadow[x.addr];
                    cmd_q.push_back(x);
                    if (!x.we) rd_q.push_back(x);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_g;
        reset  = 1'b0;
        req    = 2'b11;
        we     = 2'b00;
        lock   = 2'b00;
        addr0  = '0;
        addr1  = '0;
        wdata0 = '0;
        wdata1 = '0;
        for (int i = 0; i < 512; i++) begin
            mem[i]    = 32'h1000_0000 | i;
            shadow[i] = 32'h1000_0000 | i;
        end
        mem[5]    = 32'h0000_00AB;
        shadow[5] = 32'h0000_00AB;

        // Reset state, with requests pending
        @(negedge clk);
        check_eq("rst_gnt",    {30'd0, gnt_o},    32'd0);
        check_eq("rst_rvalid", {30'd0, rvalid_o}, 32'd0);
        check_eq("rst_wr",     {31'd0, wr},       32'd0);
        check_eq("rst_rd",     {31'd0, rd},       32'd0);
        check_eq("rst_addr",   {23'd0, addr},     32'd0);
        check_eq("rst_wdata",  wr_data,           32'd0);
        check_eq("rst_rdata",  rdata_o,           32'd0);
        check_eq("rst_lkerr",  {31'd0, lock_err_o}, 32'd0);
        req = 2'b00;
        #2 reset = 1'b1;
        tick();

        // Both ports write every cycle for four cycles
        req    = 2'b11;
        we     = 2'b11;
        addr0  = 9'd1;
        wdata0 = 32'h11;
        addr1  = 9'd2;
        wdata1 = 32'h22;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
`ifdef DMEM_ARB_FIXED_PRIO_EN
            exp_g = 2'b01;
`else
            exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
`endif
            check_eq("wr_gnt", {30'd0, gnt_o}, {30'd0, exp_g});
            tick();
        end
        req = 2'b00;
        we  = 2'b00;
        tick();
        tick();

        // Port 0 reads address 5
        req   = 2'b01;
        addr0 = 9'd5;
        @(negedge clk);
        check_eq("rd_gnt", {30'd0, gnt_o}, 32'd1);
        tick();
        req = 2'b00;
        @(negedge clk);
        check_eq("rd_strobe", {31'd0, rd}, 32'd1);
        check_eq("rd_addr",   {23'd0, addr}, 32'd5);
        tick();
        @(negedge clk);
        check_eq("rd_rvalid", {30'd0, rvalid_o}, 32'd1);
        check_eq("rd_data",   rdata_o, 32'h0000_00AB);
        tick();

        // Port 1 locks with a write to 7, holds lock three idle cycles
        req    = 2'b10;
        we     = 2'b10;
        addr1  = 9'd7;
        wdata1 = 32'h77;
        lock   = 2'b10;
        @(negedge clk);
        check_eq("lk_gnt1", {30'd0, gnt_o}, 32'd2);
        tick();
        req   = 2'b01;
        we    = 2'b00;
        addr0 = 9'd7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("lk_hold", {30'd0, gnt_o}, 32'd0);
            tick();
        end
        lock = 2'b00;
        @(negedge clk);
        check_eq("lk_release", {30'd0, gnt_o}, 32'd0);
        tick();
        @(negedge clk);
        check_eq("lk_gnt0", {30'd0, gnt_o}, 32'd1);
        tick();
        req = 2'b00;
        tick();

        // Port 1 holds the lock indefinitely: forced release
        req    = 2'b10;
        we     = 2'b10;
        addr1  = 9'd8;
        wdata1 = 32'h88;
        lock   = 2'b10;
        @(negedge clk);
        check_eq("fl_gnt1", {30'd0, gnt_o}, 32'd2);
        tick();
        req   = 2'b01;
        we    = 2'b00;
        addr0 = 9'd8;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check_eq("fl_hold", {30'd0, gnt_o}, 32'd0);
            if (i == 15) check_eq("fl_err_pre", {31'd0, lock_err_o}, 32'd0);
            tick();
        end
        @(negedge clk);
        check_eq("fl_gnt0", {30'd0, gnt_o}, 32'd1);
        check_eq("fl_err",  {31'd0, lock_err_o}, 32'd1);
        tick();
        req  = 2'b00;
        lock = 2'b00;
        tick();
        tick();

        // Reset asserted in the cycle after a port 0 read grant
        req   = 2'b01;
        addr0 = 9'd5;
        @(negedge clk);
        check_eq("rr_gnt", {30'd0, gnt_o}, 32'd1);
        tick();
        req = 2'b00;
        #1 reset = 1'b0;
        #1;
        check_eq("ar_rd",     {31'd0, rd},       32'd0);
        check_eq("ar_wr",     {31'd0, wr},       32'd0);
        check_eq("ar_addr",   {23'd0, addr},     32'd0);
        check_eq("ar_wdata",  wr_data,           32'd0);
        check_eq("ar_rvalid", {30'd0, rvalid_o}, 32'd0);
        check_eq("ar_rdata",  rdata_o,           32'd0);
        check_eq("ar_lkerr",  {31'd0, lock_err_o}, 32'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        // First simultaneous request after reset goes to port 0
        req   = 2'b11;
        we    = 2'b00;
        addr0 = 9'd1;
        addr1 = 9'd2;
        @(negedge clk);
        check_eq("pr_gnt0", {30'd0, gnt_o}, 32'd1);
        tick();
        req = 2'b10;
        @(negedge clk);
        check_eq("pr_gnt1", {30'd0, gnt_o}, 32'd2);
        tick();
        req = 2'b00;
        for (int i = 0; i < 3; i++) tick();

        @(negedge clk);
        check_eq("sb_drain", 32'(cmd_q.size() + rd_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
